// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared response codes, FSM encodings and address decode for the AXI-Lite memory slave
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_WAIT   = 2'd1,
        W_COMMIT = 2'd2,
        W_RESP   = 2'd3
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_FETCH = 2'd2,
        R_RESP  = 2'd3
    } r_state_t;

    // Hit when base <= addr < base + span; 33-bit offset so a window near the top of the map cannot wrap.
    function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                      input logic [32:0] span);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (off < span);
    endfunction

endpackage

// File: rtl/axil_bram_be.sv
// rtl/axil_bram_be.sv - single-port DEPTH x 32 RAM with byte enables and one-cycle synchronous read
module axil_bram_be #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // One access per cycle; the read register only moves on a read so a pending response stays stable.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_mem_slave.sv
// rtl/axil_mem_slave.sv - AXI4-Lite slave over on-chip RAM with programmable wait states
module axil_mem_slave
    import axil_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h01000000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

    localparam int          AW       = $clog2(DEPTH);
    localparam int          CW       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [32:0] SPAN     = 33'(4 * DEPTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    // Write channel state
    w_state_t    w_state_q, w_state_d;
    logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic        awready_q, awready_d, wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [CW-1:0] w_cnt_q, w_cnt_d;

    // Read channel state
    r_state_t    r_state_q, r_state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        r_hit_q, r_hit_d;
    logic [31:0] araddr_q, araddr_d;
    logic [CW-1:0] r_cnt_q, r_cnt_d;

    logic          aw_hs, w_hs, ar_hs;
    logic          w_hit, r_hit, w_commit, ram_re;
    logic [AW-1:0] w_idx, r_idx, ram_addr;
    logic [31:0]   ram_rdata;

    assign aw_hs    = awready_q & s_axi_awvalid;
    assign w_hs     = wready_q & s_axi_wvalid;
    assign ar_hs    = arready_q & s_axi_arvalid;
    assign w_hit    = addr_hit(awaddr_q, BASE_ADDR, SPAN);
    assign r_hit    = addr_hit(araddr_q, BASE_ADDR, SPAN);
    assign w_idx    = AW'((awaddr_q - BASE_ADDR) >> 2);
    assign r_idx    = AW'((araddr_q - BASE_ADDR) >> 2);
    assign w_commit = (w_state_q == W_COMMIT) && w_hit;
    assign ram_addr = w_commit ? w_idx : r_idx;

    // Write FSM: collect AW and W in any order, optional stall, commit, then hold B until accepted.
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        w_cnt_d   = w_cnt_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_axi_awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    if (WAIT_CYCLES > 0) begin
                        w_state_d = W_WAIT;
                        w_cnt_d   = CNT_LOAD;
                    end else begin
                        w_state_d = W_COMMIT;
                    end
                end
            end
            W_WAIT: begin
                if (w_cnt_q == '0) w_state_d = W_COMMIT;
                else               w_cnt_d   = w_cnt_q - CW'(1);
            end
            W_COMMIT: begin
                w_state_d = W_RESP;
                bvalid_d  = 1'b1;
                bresp_d   = w_hit ? RESP_OKAY : RESP_DECERR;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    // Read FSM: capture AR, optional stall, fetch (yielding the port to a same-cycle write), hold R.
    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        r_cnt_d   = r_cnt_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        r_hit_d   = r_hit_q;
        ram_re    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    araddr_d = s_axi_araddr;
                    if (WAIT_CYCLES > 0) begin
                        r_state_d = R_WAIT;
                        r_cnt_d   = CNT_LOAD;
                    end else begin
                        r_state_d = R_FETCH;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt_q == '0) r_state_d = R_FETCH;
                else               r_cnt_d   = r_cnt_q - CW'(1);
            end
            R_FETCH: begin
                if (!r_hit) begin
                    r_state_d = R_RESP;
                    rvalid_d  = 1'b1;
                    rresp_d   = RESP_DECERR;
                    r_hit_d   = 1'b0;
                end else if (!w_commit) begin
                    ram_re    = 1'b1;
                    r_state_d = R_RESP;
                    rvalid_d  = 1'b1;
                    rresp_d   = RESP_OKAY;
                    r_hit_d   = 1'b1;
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            w_cnt_q   <= '0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            r_hit_q   <= 1'b0;
            araddr_q  <= '0;
            r_cnt_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            w_cnt_q   <= w_cnt_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            r_hit_q   <= r_hit_d;
            araddr_q  <= araddr_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    axil_bram_be #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (w_commit),
        .be_i    (wstrb_q),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = r_hit_q ? ram_rdata : 32'h0;

endmodule
